// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hit path, one outstanding line fill.
// Optional build macro ICACHE_FLUSH_EN adds the flush port and the DRAIN state.
module icache_assoc #(
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     cache_en,
   input  logic                     cache_st,
   input  logic                     cache_rb,
   input  logic [31:0]              if_addr,
   output logic                     if_cache_hit,
   output logic [31:0]              if_hit_word,
   output logic                     mc_fc_ena,
   output logic [31:0]              mc_fc_addr,
   input  logic                     mc_fc_done,
   input  logic [32*LINE_WORDS-1:0] mc_fc_line
`ifdef ICACHE_FLUSH_EN
   ,
   input  logic                     flush
`endif
);

   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = WORD_W + 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int LINE_W = 32 * LINE_WORDS;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

`ifdef ICACHE_FLUSH_EN
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

   state_t state_q, state_d;

   logic [LINE_W-1:0] line_mem [SETS][WAYS];
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q  [SETS];
   logic [WAY_W-1:0]  rr_q     [SETS];

   logic [TAG_W-1:0]  tag_a;
   logic [IDX_W-1:0]  set_a;
   logic [WORD_W-1:0] word_a;
   logic              unused_addr_lsb;

   logic [WAY_W-1:0]  vic_way;
   logic              vic_rr;
   logic [WAY_W-1:0]  vway_q;
   logic              vrr_q;

   logic [TAG_W-1:0]  fill_tag;
   logic [IDX_W-1:0]  fill_set;

   logic              flush_i;
   logic              miss_req;
   logic              req;
   logic              fill;
   logic              fc_end;

   assign tag_a           = if_addr[31 -: TAG_W];
   assign set_a           = if_addr[OFF_W +: IDX_W];
   assign word_a          = if_addr[2 +: WORD_W];
   assign unused_addr_lsb = &{1'b0, if_addr[1:0]};

   // The pending fill's tag and set come from the held request address.
   assign fill_tag = mc_fc_addr[31 -: TAG_W];
   assign fill_set = mc_fc_addr[OFF_W +: IDX_W];

`ifdef ICACHE_FLUSH_EN
   assign flush_i = rdy & flush;
`else
   assign flush_i = 1'b0;
`endif

   always_comb begin
      if_cache_hit = 1'b0;
      if_hit_word  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[set_a][w] && (tag_mem[set_a][w] == tag_a)) begin
            if_cache_hit = 1'b1;
            if_hit_word  = line_mem[set_a][w][{word_a, 5'd0} +: 32];
         end
      end
   end

   // Lowest invalid way wins; round-robin only when the set is full.
   always_comb begin
      vic_way = rr_q[set_a];
      vic_rr  = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[set_a][w]) begin
            vic_way = WAY_W'(w);
            vic_rr  = 1'b0;
         end
      end
   end

   assign miss_req = rdy & ~if_cache_hit & cache_en & ~cache_st & ~cache_rb & ~flush_i;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else if (rdy)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      fill    = 1'b0;
      fc_end  = 1'b0;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (miss_req) begin
                  state_d = FETCH;
                  req     = 1'b1;
               end
            end
            FETCH: begin
`ifdef ICACHE_FLUSH_EN
               if (flush && mc_fc_done) begin
                  state_d = IDLE;
                  fc_end  = 1'b1;
               end else if (flush) begin
                  state_d = DRAIN;
               end else
`endif
               if (mc_fc_done) begin
                  state_d = IDLE;
                  fill    = 1'b1;
                  fc_end  = 1'b1;
               end
            end
`ifdef ICACHE_FLUSH_EN
            DRAIN: begin
               if (mc_fc_done) begin
                  state_d = IDLE;
                  fc_end  = 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc_fc_ena  <= 1'b0;
         mc_fc_addr <= '0;
      end else if (req) begin
         mc_fc_ena  <= 1'b1;
         mc_fc_addr <= {if_addr[31:OFF_W], OFF_W'(0)};
      end else if (fc_end) begin
         mc_fc_ena  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (req) begin
         vway_q <= vic_way;
         vrr_q  <= vic_rr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (flush_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (fill) begin
         valid_q[fill_set][vway_q] <= 1'b1;
         if (vrr_q)
            rr_q[fill_set] <= (rr_q[fill_set] == WAY_W'(WAYS - 1)) ? '0
                                                                    : rr_q[fill_set] + WAY_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         line_mem[fill_set][vway_q] <= mc_fc_line;
         tag_mem[fill_set][vway_q]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (WAYS=2, SETS=64, LINE_WORDS=4).
module tb_icache_assoc;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rdy = 1'b1;
   logic         cache_en = 1'b0;
   logic         cache_st = 1'b0;
   logic         cache_rb = 1'b0;
   logic [31:0]  if_addr = '0;
   logic         if_cache_hit;
   logic [31:0]  if_hit_word;
   logic         mc_fc_ena;
   logic [31:0]  mc_fc_addr;
   logic         mc_fc_done = 1'b0;
   logic [127:0] mc_fc_line = '0;
`ifdef ICACHE_FLUSH_EN
   logic         flush = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   icache_assoc #(.WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .cache_en(cache_en),
      .cache_st(cache_st),
      .cache_rb(cache_rb),
      .if_addr(if_addr),
      .if_cache_hit(if_cache_hit),
      .if_hit_word(if_hit_word),
      .mc_fc_ena(mc_fc_ena),
      .mc_fc_addr(mc_fc_addr),
      .mc_fc_done(mc_fc_done),
      .mc_fc_line(mc_fc_line)
`ifdef ICACHE_FLUSH_EN
      ,
      .flush(flush)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        hit;
      logic [31:0] word;
   } look_t;

   typedef struct {
      logic r;
      logic en;
      logic st;
      logic rb;
   } stall_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Fill data: word k of the line at a = {a[31:4], k} ^ 0x5A000000.
   function automatic logic [127:0] mk_line(input logic [31:0] a);
      logic [127:0] l;
      for (int k = 0; k < 4; k++)
         l[32*k +: 32] = {a[31:4], 4'(k)} ^ 32'h5A00_0000;
      return l;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string name, input logic [31:0] a, input logic h, input logic [31:0] w);
      cache_en = 1'b0;
      if_addr  = a;
      #1;
      check({name, "_hit"}, 32'(if_cache_hit), 32'(h));
      check({name, "_word"}, if_hit_word, w);
   endtask

   task automatic fill(input string name, input logic [31:0] a, input logic [127:0] line);
      if_addr  = a;
      cache_en = 1'b1;
      step();
      check({name, "_req_ena"}, 32'(mc_fc_ena), 32'd1);
      check({name, "_req_addr"}, mc_fc_addr, {a[31:4], 4'h0});
      cache_en   = 1'b0;
      mc_fc_done = 1'b1;
      mc_fc_line = line;
      step();
      mc_fc_done = 1'b0;
      check({name, "_end_ena"}, 32'(mc_fc_ena), 32'd0);
   endtask

   look_t  looks [8];
   stall_t stalls [4];

   initial begin
      looks[0] = '{32'h0000_0434, 1'b1, 32'h5A00_0431};
      looks[1] = '{32'h0000_0838, 1'b0, 32'h0000_0000};
      looks[2] = '{32'h0000_0C3C, 1'b1, 32'h5A00_0C33};
      looks[3] = '{32'h0000_1234, 1'b1, 32'h0B0B_0B0B};
      looks[4] = '{32'h0000_1230, 1'b1, 32'h0A0A_0A0A};
      looks[5] = '{32'h0000_1238, 1'b1, 32'h0C0C_0C0C};
      looks[6] = '{32'h0000_123F, 1'b1, 32'h0D0D_0D0D};
      looks[7] = '{32'h0000_2030, 1'b0, 32'h0000_0000};

      stalls[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
      stalls[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
      stalls[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
      stalls[3] = '{1'b0, 1'b1, 1'b0, 1'b0};

      // reset state
      step();
      step();
      rst = 1'b0;
      check("rst_ena", 32'(mc_fc_ena), 32'd0);
      check("rst_addr", mc_fc_addr, 32'd0);
      lookup("rst_look", 32'h0000_1234, 1'b0, 32'd0);

      // cold miss, line {D,C,B,A}
      fill("cold", 32'h0000_1234, {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A});
      lookup("cold_look", 32'h0000_1234, 1'b1, 32'h0B0B_0B0B);

      // three tags in set 3: invalid ways first, then round-robin from way 0
      fill("s3_t1", 32'h0000_0430, mk_line(32'h0000_0430));
      fill("s3_t2", 32'h0000_0830, mk_line(32'h0000_0830));
      lookup("s3_t1_res", 32'h0000_0430, 1'b1, 32'h5A00_0430);
      fill("s3_t3", 32'h0000_0C30, mk_line(32'h0000_0C30));
      lookup("evict_t1", 32'h0000_0430, 1'b0, 32'd0);
      lookup("keep_t2", 32'h0000_0834, 1'b1, 32'h5A00_0831);
      lookup("keep_t3", 32'h0000_0C30, 1'b1, 32'h5A00_0C30);
      // pointer moved to way 1, so refetching tag 1 evicts tag 2
      fill("s3_t1b", 32'h0000_0430, mk_line(32'h0000_0430));
      for (int i = 0; i < 8; i++)
         lookup($sformatf("tab%0d", i), looks[i].addr, looks[i].hit, looks[i].word);

      // hit under miss
      if_addr  = 32'h0000_2000;
      cache_en = 1'b1;
      step();
      check("hum_req_ena", 32'(mc_fc_ena), 32'd1);
      check("hum_req_addr", mc_fc_addr, 32'h0000_2000);
      if_addr = 32'h0000_1234;
      #1;
      check("hum_hit", 32'(if_cache_hit), 32'd1);
      check("hum_word", if_hit_word, 32'h0B0B_0B0B);
      step();
      if_addr = 32'h0000_5000;
      step();
      check("hum_no_reissue", mc_fc_addr, 32'h0000_2000);
      check("hum_ena_held", 32'(mc_fc_ena), 32'd1);
      cache_en   = 1'b0;
      mc_fc_done = 1'b1;
      mc_fc_line = mk_line(32'h0000_2000);
      step();
      mc_fc_done = 1'b0;
      check("hum_end_ena", 32'(mc_fc_ena), 32'd0);
      lookup("hum_fill", 32'h0000_200C, 1'b1, 32'h5A00_2003);

      // request blocking conditions
      if_addr = 32'h0000_6000;
      for (int i = 0; i < 4; i++) begin
         rdy      = stalls[i].r;
         cache_en = stalls[i].en;
         cache_st = stalls[i].st;
         cache_rb = stalls[i].rb;
         step();
         check($sformatf("stall%0d_ena", i), 32'(mc_fc_ena), 32'd0);
      end
      rdy      = 1'b1;
      cache_en = 1'b1;
      cache_st = 1'b0;
      cache_rb = 1'b0;
      step();
      check("unstall_ena", 32'(mc_fc_ena), 32'd1);
      check("unstall_addr", mc_fc_addr, 32'h0000_6000);
      cache_en   = 1'b0;
      mc_fc_done = 1'b1;
      mc_fc_line = mk_line(32'h0000_6000);
      step();
      mc_fc_done = 1'b0;
      lookup("unstall_fill", 32'h0000_6008, 1'b1, 32'h5A00_6002);

      // reset during a fill
      if_addr  = 32'h0000_7000;
      cache_en = 1'b1;
      step();
      check("rfetch_ena", 32'(mc_fc_ena), 32'd1);
      cache_en = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      check("rmid_ena", 32'(mc_fc_ena), 32'd0);
      check("rmid_addr", mc_fc_addr, 32'd0);
      lookup("rmid_a", 32'h0000_1234, 1'b0, 32'd0);
      lookup("rmid_b", 32'h0000_0C30, 1'b0, 32'd0);
      lookup("rmid_c", 32'h0000_6008, 1'b0, 32'd0);
      fill("post_rst", 32'h0000_1234, mk_line(32'h0000_1234));
      lookup("post_rst_look", 32'h0000_1234, 1'b1, 32'h5A00_1231);

`ifdef ICACHE_FLUSH_EN
      // flush during a fill: line discarded, everything invalid
      if_addr  = 32'h0000_3000;
      cache_en = 1'b1;
      step();
      check("fl_req_ena", 32'(mc_fc_ena), 32'd1);
      cache_en = 1'b0;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      check("fl_drain_ena", 32'(mc_fc_ena), 32'd1);
      lookup("fl_cleared", 32'h0000_1234, 1'b0, 32'd0);
      step();
      check("fl_drain_ena2", 32'(mc_fc_ena), 32'd1);
      mc_fc_done = 1'b1;
      mc_fc_line = mk_line(32'h0000_3000);
      step();
      mc_fc_done = 1'b0;
      check("fl_end_ena", 32'(mc_fc_ena), 32'd0);
      lookup("fl_discard", 32'h0000_3000, 1'b0, 32'd0);
      fill("fl_refill", 32'h0000_3000, mk_line(32'h0000_3000));
      lookup("fl_refill_look", 32'h0000_3004, 1'b1, 32'h5A00_3001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
